// File: rtl/sysarr_out_drain_pkg.sv
// sysarr_pkg: shared FSM state type and default geometry for the systolic-array drain stage.
package sysarr_pkg;
   typedef enum logic [1:0] {IDLE, DRAIN, DONE} drain_state_t;
   localparam int N_DEF      = 4;
   localparam int WIDTH_DEF  = 16;
   localparam int DEPTH_DEF  = 2;
   localparam int ADDR_W_DEF = 16;
endpackage

// File: rtl/sysarr_out_drain_if.sv
// sysarr_out_drain_if: row-capture, scratchpad write and status signals of the drain stage.
interface sysarr_out_drain_if
   import sysarr_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic                start;
   logic [ADDR_W-1:0]   base_addr;
   logic                row_valid;
   logic [N*WIDTH-1:0]  row_in;
   logic                wr_valid;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr;
   logic [N*WIDTH-1:0]  wr_data;
   logic                busy;
   logic                tile_done;
   logic                overflow_err;
   modport master (
      input  start, base_addr, row_valid, row_in, wr_ready,
      output wr_valid, wr_addr, wr_data, busy, tile_done, overflow_err
   );
   modport slave (
      output start, base_addr, row_valid, row_in, wr_ready,
      input  wr_valid, wr_addr, wr_data, busy, tile_done, overflow_err
   );
endinterface

// File: rtl/sysarr_out_drain_buf.sv
// sysarr_drain_buf: DEPTH-entry synchronous row FIFO; head is read straight from the storage registers.
module sysarr_drain_buf
   import sysarr_pkg::*;
#(
   parameter int W     = N_DEF * WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wp_q, rp_q;
   logic [PW:0]   cnt_q;
   assign full_o  = cnt_q == (PW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign head_o  = mem_q[rp_q];
   always_ff @(posedge clk)
      if (push_i) mem_q[wp_q] <= din_i;
   // DEPTH is a power of two, so pointers wrap by plain overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_q + PW'(push_i);
         rp_q  <= rp_q + PW'(pop_i);
         cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
      end
   end
endmodule

// File: rtl/sysarr_out_drain.sv
// sysarr_out_drain: buffers completed result rows and writes N of them per tile to the scratchpad.
// Define OUT_DRAIN_RELU_EN to clamp negative elements to zero as rows enter the buffer.
module sysarr_out_drain
   import sysarr_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int STRIDE = 1
) (
   input  logic             clk,
   input  logic             RST,
   sysarr_out_drain_if.master bus
);
   localparam int RW = N * WIDTH;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] N_C = CW'(N);
   drain_state_t      state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CW-1:0]     rows_q, rows_d, wcnt_q, wcnt_d;
   logic              ovf_q, ovf_d;
   logic              full, empty, push, pop, drain, want;
   logic [RW-1:0]     head, row_w;
`ifdef OUT_DRAIN_RELU_EN
   always_comb begin
      row_w = bus.row_in;
      for (int i = 0; i < N; i++)
         if (bus.row_in[i*WIDTH+WIDTH-1]) row_w[i*WIDTH +: WIDTH] = '0;
   end
`else
   assign row_w = bus.row_in;
`endif
   assign drain = state_q == DRAIN;
   assign pop   = drain && !empty && bus.wr_ready;
   assign want  = drain && bus.row_valid && rows_q != N_C;
   // a full buffer still takes a row when its head leaves in the same cycle
   assign push  = want && (!full || pop);
   sysarr_drain_buf #(.W(RW), .DEPTH(DEPTH)) u_buf (
      .clk     (clk),
      .rst     (RST),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (row_w),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head)
   );
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      rows_d  = rows_q + CW'(push);
      wcnt_d  = wcnt_q + CW'(pop);
      ovf_d   = ovf_q | (want && full && !pop);
      if (state_q == IDLE && bus.start) begin
         state_d = DRAIN;
         base_d  = bus.base_addr;
         rows_d  = '0;
         wcnt_d  = '0;
      end
      if (pop && wcnt_q == N_C - 1'b1) state_d = DONE;
      if (state_q == DONE) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= IDLE;
         base_q  <= '0;
         rows_q  <= '0;
         wcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         rows_q  <= rows_d;
         wcnt_q  <= wcnt_d;
         ovf_q   <= ovf_d;
      end
   end
   assign bus.wr_valid     = drain && !empty;
   assign bus.wr_addr      = bus.wr_valid ? base_q + ADDR_W'(wcnt_q * STRIDE) : '0;
   assign bus.wr_data      = bus.wr_valid ? head : '0;
   assign bus.busy         = state_q != IDLE;
   assign bus.tile_done    = state_q == DONE;
   assign bus.overflow_err = ovf_q;
endmodule

// File: tb/tb_sysarr_out_drain.sv
// tb_sysarr_out_drain: directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_sysarr_out_drain;
   import sysarr_pkg::*;
   localparam int N = 4, W = 16, D = 2, AW = 16, STRIDE = 1, RW = N * W;
   logic clk = 1'b0;
   logic RST = 1'b1;
   always #5 clk = ~clk;
   sysarr_out_drain_if #(.N(N), .WIDTH(W), .ADDR_W(AW)) bus ();
   sysarr_out_drain #(.N(N), .WIDTH(W), .DEPTH(D), .ADDR_W(AW), .STRIDE(STRIDE)) dut (
      .clk (clk),
      .RST (RST),
      .bus (bus)
   );
   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // reference model: 0=idle 1=drain 2=done, buffer as a bounded queue
   int mst, mrows, mwcnt;
   logic [AW-1:0] mbase;
   bit movf, mpop;
   logic [RW-1:0] mq[$];
   function automatic logic [RW-1:0] relu(logic [RW-1:0] r);
`ifdef OUT_DRAIN_RELU_EN
      for (int i = 0; i < N; i++) if (r[i*W+W-1]) r[i*W +: W] = '0;
`endif
      return r;
   endfunction
   always @(posedge clk) begin
      cyc++;
      if (RST) begin
         mst = 0; mbase = '0; mrows = 0; mwcnt = 0; movf = 1'b0;
         mq.delete();
      end else if (mst == 0) begin
         if (bus.start) begin
            mst = 1; mbase = bus.base_addr; mrows = 0; mwcnt = 0;
         end
      end else if (mst == 2) begin
         mst = 0;
      end else begin
         mpop = mq.size() > 0 && bus.wr_ready;
         if (mpop) begin
            void'(mq.pop_front());
            mwcnt++;
         end
         if (bus.row_valid && mrows < N) begin
            if (mq.size() < D) begin
               mq.push_back(relu(bus.row_in));
               mrows++;
            end else movf = 1'b1;
         end
         if (mwcnt == N) mst = 2;
      end
   end
   logic          ev;
   logic [AW-1:0] ea;
   logic [RW-1:0] ed;
   logic [AW-1:0] act_a[$];
   logic [RW-1:0] act_d[$];
   int hs_cyc = 0, td_cyc = 0, td_cnt = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         ev = mst == 1 && mq.size() > 0;
         ea = ev ? AW'(mbase + AW'(mwcnt * STRIDE)) : '0;
         ed = ev ? mq[0] : '0;
         check("wr_valid", bus.wr_valid, ev);
         check("wr_addr", bus.wr_addr, ea);
         check("wr_data", bus.wr_data, ed);
         check("busy", bus.busy, mst != 0);
         check("tile_done", bus.tile_done, mst == 2);
         check("overflow_err", bus.overflow_err, movf);
      end
      if (bus.wr_valid && bus.wr_ready) begin
         act_a.push_back(bus.wr_addr);
         act_d.push_back(bus.wr_data);
         hs_cyc = cyc;
      end
      if (bus.tile_done) begin
         td_cyc = cyc;
         td_cnt++;
      end
   end
   function automatic logic [RW-1:0] rowv(int k);
      logic [RW-1:0] r;
      for (int e = 0; e < N; e++) r[e*W +: W] = W'(k * 16 + e + 1);
      return r;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      act_a.delete();
      act_d.delete();
   endtask
   task automatic do_start(logic [AW-1:0] b);
      bus.start = 1'b1;
      bus.base_addr = b;
      tick();
      bus.start = 1'b0;
   endtask
   task automatic send_row(logic [RW-1:0] r);
      bus.row_valid = 1'b1;
      bus.row_in = r;
      tick();
      bus.row_valid = 1'b0;
   endtask
   task automatic wait_idle(string name, int budget);
      int n = 0;
      while (bus.busy && n < budget) begin
         tick();
         n++;
      end
      check({name, "_idle_bound"}, bus.busy, 1'b0);
   endtask
   task automatic check_writes(string name, logic [AW-1:0] b, int first);
      check({name, "_count"}, act_a.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_addr%0d", name, i), act_a[i], AW'(b + i));
         check($sformatf("%s_data%0d", name, i), act_d[i], rowv(first + i));
      end
   endtask
   logic [RW-1:0] r5, d0;
   logic [W-1:0] e0_exp;
   int n;
   initial begin
      bus.start = 1'b0; bus.base_addr = '0; bus.row_valid = 1'b0; bus.row_in = '0; bus.wr_ready = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      chk_en = 1'b1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_wr_valid", bus.wr_valid, 1'b0);
      check("rst_tile_done", bus.tile_done, 1'b0);
      check("rst_ovf", bus.overflow_err, 1'b0);
      // 1: plain drain at 0x100
      bus.wr_ready = 1'b1;
      do_start(16'h0100);
      for (int k = 0; k < 4; k++) send_row(rowv(k));
      wait_idle("t1", 20);
      check_writes("t1", 16'h0100, 0);
      check("t1_done_lat", td_cyc - hs_cyc, 1);
      check("t1_model_wcnt", mwcnt, 4);
      // 2: stalled scratchpad, two rows dropped
      do_reset();
      bus.wr_ready = 1'b0;
      do_start(16'h0200);
      for (int k = 0; k < 4; k++) send_row(rowv(k));
      tick();
      check("t2_ovf", bus.overflow_err, 1'b1);
      check("t2_stall_addr", bus.wr_addr, 16'h0200);
      check("t2_stall_data", bus.wr_data, rowv(0));
      check("t2_no_writes", act_a.size(), 0);
      bus.wr_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      check("t2_writes", act_a.size(), 2);
      check("t2_data1", act_d[1], rowv(1));
      check("t2_ovf_sticky", bus.overflow_err, 1'b1);
      check("t2_stuck_busy", bus.busy, 1'b1);
      do_reset();
      check("t2_ovf_cleared", bus.overflow_err, 1'b0);
      // 3: alternating ready with a row every cycle
      do_start(16'h0300);
      for (int i = 0; i < 10; i++) begin
         bus.wr_ready = i[0];
         bus.row_valid = i < 4;
         bus.row_in = rowv(4 + i);
         tick();
      end
      bus.row_valid = 1'b0;
      bus.wr_ready = 1'b1;
      wait_idle("t3", 20);
      check_writes("t3", 16'h0300, 4);
      check("t3_ovf", bus.overflow_err, 1'b0);
      // 4/5: address wrap and element clamp
      do_reset();
      r5 = rowv(9);
      r5[31:0] = 32'h7FFF_8001;
      do_start(16'hFFFE);
      send_row(r5);
      for (int k = 1; k < 4; k++) send_row(rowv(9 + k));
      wait_idle("t4", 20);
      check("t4_count", act_a.size(), 4);
      check("t4_addr0", act_a[0], 16'hFFFE);
      check("t4_addr1", act_a[1], 16'hFFFF);
      check("t4_addr2", act_a[2], 16'h0000);
      check("t4_addr3", act_a[3], 16'h0001);
`ifdef OUT_DRAIN_RELU_EN
      e0_exp = 16'h0000;
`else
      e0_exp = 16'h8001;
`endif
      d0 = act_d[0];
      check("t5_elem0", d0[15:0], e0_exp);
      check("t5_elem1", d0[31:16], 16'h7FFF);
      // 6: reset mid-tile, then a clean tile
      do_reset();
      do_start(16'h0400);
      send_row(rowv(20));
      send_row(rowv(21));
      n = 0;
      while (act_a.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      check("t6_two_written", act_a.size(), 2);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("t6_busy", bus.busy, 1'b0);
      check("t6_wr_valid", bus.wr_valid, 1'b0);
      check("t6_wr_addr", bus.wr_addr, 16'h0000);
      check("t6_wr_data", bus.wr_data, 64'h0);
      act_a.delete();
      act_d.delete();
      do_start(16'h0500);
      for (int k = 0; k < 4; k++) send_row(rowv(30 + k));
      wait_idle("t6", 20);
      check_writes("t6", 16'h0500, 30);
      // random traffic against the model
      td_cnt = 0;
      for (int i = 0; i < 4000; i++) begin
         RST = $urandom_range(0, 149) == 0;
         bus.start = $urandom_range(0, 5) == 0;
         bus.base_addr = AW'($urandom);
         bus.row_valid = $urandom_range(0, 1) == 1;
         bus.row_in = {$urandom, $urandom};
         bus.wr_ready = $urandom_range(0, 3) != 0;
         tick();
      end
      check("rand_tiles_done", td_cnt > 0, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
